// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Request/ready arbiter that shares one single-ported synchronous memory
//   between the instruction fetch port and the load/store data port.
//   Stores are lane-aligned with byte enables; loads are lane-extracted and
//   zero/sign-extended. Misaligned accesses never touch memory and return an
//   error response one cycle later.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request and byte address
//   if_rdata/if_ready/if_err       fetch response (ready is a 1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata      data request, store flag, address, data
//   d_size/d_signed                access size (00 B, 01 H, 1x W), sign-extend
//   d_rdata/d_ready/d_err          data response (ready is a 1-cycle pulse)
//   stall                          a request is waiting without its ready
//   m_en/m_we/m_addr/m_wdata       memory strobe, byte enables, word addr, data
//   m_rdata                        memory read data, one cycle after m_en
//
// Optional build macro MEM_ARB_PERF_EN adds parameter PERF_W and saturating
// counters perf_conflicts (both requesters eligible) and perf_stalls.
module mem_port_arbiter #(
    parameter int ADDR_W = 12
`ifdef MEM_ARB_PERF_EN
    ,
    parameter int PERF_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              d_err,
    output logic              stall,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-3:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_conflicts,
    output logic [PERF_W-1:0] perf_stalls
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_IF,
        S_BUSY_D,
        S_ERR_IF,
        S_ERR_D
    } state_t;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    state_t     state_q;
    logic       last_gnt_q;
    logic       if_ready_q, if_err_q, d_ready_q, d_err_q;

    // Data-side request captured at grant; only consulted in S_BUSY_D.
    logic [1:0] d_lo_q;
    logic [1:0] d_size_q;
    logic       d_signed_q;
    logic       d_we_q;

    logic       if_elig, d_elig, pick_if, pick_d, if_mis, d_mis;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   return 4'b0001 << lo;
            2'b01:   return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'b00:   return {4{w[7:0]}};
            2'b01:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lo,
                                                 input logic sgn, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lo, 3'b000});
        h = lo[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   return {{24{sgn & b[7]}}, b};
            2'b01:   return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // A requester whose ready is out this cycle is done; it may not be
    // re-granted, which lets the other side take the memory immediately.
    assign if_elig = if_req && !if_ready_q;
    assign d_elig  = d_req && !d_ready_q;

    // Round-robin: on conflict the data port wins unless it won last time.
    assign pick_d  = d_elig && (!if_elig || (last_gnt_q == GNT_IF));
    assign pick_if = if_elig && !pick_d;

    assign if_mis  = if_addr[1:0] != 2'b00;
    assign d_mis   = misaligned(d_size, d_addr[1:0]);

    // Memory side is driven combinationally from the grant; rst blocks any
    // strobe so a store granted during reset cannot write.
    always_comb begin
        m_en    = 1'b0;
        m_we    = 4'b0000;
        m_addr  = '0;
        m_wdata = '0;
        if (!rst) begin
            if (pick_d) begin
                m_en   = !d_mis;
                m_addr = d_addr[ADDR_W-1:2];
                if (d_we && !d_mis) begin
                    m_we    = store_be(d_size, d_addr[1:0]);
                    m_wdata = store_data(d_size, d_wdata);
                end
            end else if (pick_if) begin
                m_en   = !if_mis;
                m_addr = if_addr[ADDR_W-1:2];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            last_gnt_q <= GNT_IF;
            if_ready_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_ready_q  <= 1'b0;
            d_err_q    <= 1'b0;
        end else begin
            if_ready_q <= 1'b0;
            if_err_q   <= 1'b0;
            d_ready_q  <= 1'b0;
            d_err_q    <= 1'b0;
            if (pick_d) begin
                state_q    <= d_mis ? S_ERR_D : S_BUSY_D;
                last_gnt_q <= GNT_D;
                d_ready_q  <= 1'b1;
                d_err_q    <= d_mis;
            end else if (pick_if) begin
                state_q    <= if_mis ? S_ERR_IF : S_BUSY_IF;
                last_gnt_q <= GNT_IF;
                if_ready_q <= 1'b1;
                if_err_q   <= if_mis;
            end else begin
                state_q    <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pick_d) begin
            d_lo_q     <= d_addr[1:0];
            d_size_q   <= d_size;
            d_signed_q <= d_signed;
            d_we_q     <= d_we;
        end
    end

    assign if_ready = if_ready_q;
    assign if_err   = if_err_q;
    assign d_ready  = d_ready_q;
    assign d_err    = d_err_q;
    assign if_rdata = (state_q == S_BUSY_IF) ? m_rdata : 32'h0;
    assign d_rdata  = (state_q == S_BUSY_D && !d_we_q)
                      ? load_extract(d_size_q, d_lo_q, d_signed_q, m_rdata) : 32'h0;
    assign stall    = !rst && (if_elig || d_elig);

`ifdef MEM_ARB_PERF_EN
    logic [PERF_W-1:0] conf_q, stl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_q <= '0;
            stl_q  <= '0;
        end else begin
            if (if_elig && d_elig && !(&conf_q)) conf_q <= conf_q + 1'b1;
            if (stall && !(&stl_q))              stl_q  <= stl_q + 1'b1;
        end
    end

    assign perf_conflicts = conf_q;
    assign perf_stalls    = stl_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed and randomized bench for mem_port_arbiter. A behavioural memory
//   answers the DUT's m_* port; a byte-array reference model predicts every
//   load result, byte enable pattern and error response.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_ready, if_err;
    logic              d_req, d_we, d_signed;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic [1:0]        d_size;
    logic [31:0]       d_rdata;
    logic              d_ready, d_err, stall;
    logic              m_en;
    logic [3:0]        m_we;
    logic [ADDR_W-3:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] mem_w;
    logic [7:0]  ref_mem [0:4095];

    int n_cmp = 0;
    int n_bad = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_signed(d_signed), .d_rdata(d_rdata),
        .d_ready(d_ready), .d_err(d_err), .stall(stall),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)     return 32'h0050_0093;
        if (i == 'h40)  return 32'h8001_1234;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Behavioural synchronous memory: registered read, byte-enabled write.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        m_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (m_en) begin
                mem_w = mem[m_addr];
                for (int b = 0; b < 4; b++)
                    if (m_we[b]) mem_w[8*b +: 8] = m_wdata[8*b +: 8];
                m_rdata     <= mem[m_addr];
                mem[m_addr] <= mem_w;
            end
        end
    end

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input int a, input logic sgn);
        int n, v;
        n = nbytes(size);
        v = 0;
        for (int k = n - 1; k >= 0; k--) v = v * 256 + int'(ref_mem[a + k]);
        if (sgn && n < 4 && v >= (1 << (8 * n - 1))) v = v - (1 << (8 * n));
        return 32'(v);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_access(input string tag, input logic we, input logic [1:0] size,
                            input int a, input logic [31:0] wd, input logic sgn);
        int n;
        logic mis;
        logic [3:0] exp_we;
        logic [31:0] exp_wd, exp_rd;
        n   = nbytes(size);
        mis = (a % n) != 0;
        exp_we = 4'b0000;
        exp_wd = 32'h0;
        for (int j = 0; j < 4; j++) exp_wd[8*j +: 8] = wd[8*(j % n) +: 8];
        for (int k = 0; k < n; k++) exp_we[(a % 4) + k] = 1'b1;
        exp_rd = (mis || we) ? 32'h0 : ref_load(size, a, sgn);
        d_we = we; d_size = size; d_addr = ADDR_W'(a); d_wdata = wd; d_signed = sgn;
        d_req = 1'b1;
        #1;
        check({tag, ".m_en"}, 32'(m_en), 32'(!mis));
        check({tag, ".stall"}, 32'(stall), 32'd1);
        if (!mis) begin
            check({tag, ".m_addr"}, 32'(m_addr), 32'(a / 4));
            check({tag, ".m_we"}, 32'(m_we), (we ? 32'(exp_we) : 32'h0));
            if (we) begin
                check({tag, ".m_wdata"}, m_wdata, exp_wd);
                for (int k = 0; k < n; k++) ref_mem[a + k] = wd[8*k +: 8];
            end
        end
        tick();
        check({tag, ".ready"}, 32'(d_ready), 32'd1);
        check({tag, ".err"}, 32'(d_err), 32'(mis));
        check({tag, ".rdata"}, d_rdata, exp_rd);
        d_req = 1'b0;
        tick();
        check({tag, ".ready_drop"}, 32'({d_ready, d_err}), 32'd0);
    endtask

    task automatic fetch(input string tag, input int a);
        logic mis;
        logic [31:0] exp_rd;
        mis    = (a % 4) != 0;
        exp_rd = mis ? 32'h0 : ref_load(2'b10, a, 1'b0);
        if_addr = ADDR_W'(a);
        if_req  = 1'b1;
        #1;
        check({tag, ".m_en"}, 32'(m_en), 32'(!mis));
        if (!mis) check({tag, ".m_addr"}, 32'(m_addr), 32'(a / 4));
        tick();
        check({tag, ".ready"}, 32'(if_ready), 32'd1);
        check({tag, ".err"}, 32'(if_err), 32'(mis));
        check({tag, ".rdata"}, if_rdata, exp_rd);
        if_req = 1'b0;
        tick();
        check({tag, ".ready_drop"}, 32'({if_ready, if_err}), 32'd0);
    endtask

    initial begin
        logic [31:0] tmp;
        logic        exp_d;
        for (int i = 0; i < 1024; i++) begin
            tmp = init_word(i);
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = tmp[8*b +: 8];
        end
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_size = 2'b00; d_signed = 1'b0;
        repeat (3) tick();
        check("reset.outputs", {22'd0, if_ready, if_err, d_ready, d_err, stall, m_en, m_we},
              32'h0);
        check("reset.rdata", if_rdata | d_rdata | m_wdata, 32'h0);
        rst = 1'b0;
        tick();

        // Directed cases from the feature list.
        fetch("fetch_010", 'h010);
        check("fetch_010.value", 32'h0050_0093, ref_load(2'b10, 'h010, 1'b0));
        d_access("ldh_s_102", 1'b0, 2'b01, 'h102, 32'h0, 1'b1);
        d_access("ldh_u_102", 1'b0, 2'b01, 'h102, 32'h0, 1'b0);
        d_access("stb_103", 1'b1, 2'b00, 'h103, 32'h0000_00AB, 1'b0);
        d_access("ldb_s_103", 1'b0, 2'b00, 'h103, 32'h0, 1'b1);
        d_access("ldw_0a2_mis", 1'b0, 2'b10, 'h0A2, 32'h0, 1'b0);
        d_access("sth_101_mis", 1'b1, 2'b01, 'h101, 32'h1234_5678, 1'b0);
        fetch("fetch_011_mis", 'h011);
        fetch("fetch_020", 'h020);

        // Conflict: last grant was IF, so D, IF, D, IF on consecutive cycles.
        if_addr = ADDR_W'('h020); if_req = 1'b1;
        d_addr = ADDR_W'('h040); d_size = 2'b10; d_we = 1'b0; d_signed = 1'b0; d_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            exp_d = (c % 2) == 0;
            check($sformatf("rr%0d.m_addr", c), 32'(m_addr), exp_d ? 32'h10 : 32'h08);
            check($sformatf("rr%0d.m_en", c), 32'(m_en), 32'd1);
            check($sformatf("rr%0d.stall", c), 32'(stall), 32'd1);
            check($sformatf("rr%0d.d_ready", c), 32'(d_ready), 32'(c % 2 == 1));
            check($sformatf("rr%0d.if_ready", c), 32'(if_ready), 32'(c >= 2 && c % 2 == 0));
            if (d_ready) check($sformatf("rr%0d.d_rdata", c), d_rdata,
                               ref_load(2'b10, 'h040, 1'b0));
            if (if_ready) check($sformatf("rr%0d.if_rdata", c), if_rdata,
                                ref_load(2'b10, 'h020, 1'b0));
            tick();
        end
        if_req = 1'b0; d_req = 1'b0;
        #1;
        check("rr4.if_ready", 32'(if_ready), 32'd1);
        check("rr4.if_rdata", if_rdata, ref_load(2'b10, 'h020, 1'b0));
        check("rr4.idle", 32'({m_en, stall, d_ready}), 32'd0);
        tick();
        check("rr5.ready_drop", 32'({if_ready, d_ready}), 32'd0);

        // Reset lands in the same cycle a store is granted.
        d_we = 1'b1; d_size = 2'b10; d_addr = ADDR_W'('h104); d_wdata = 32'hDEAD_BEEF;
        d_req = 1'b1;
        #1;
        check("rststore.granted_we", 32'(m_we), 32'hF);
        rst = 1'b1;
        #1;
        check("rststore.m_we", 32'(m_we), 32'h0);
        check("rststore.m_en", 32'(m_en), 32'h0);
        tick();
        check("rststore.no_ready", 32'(d_ready), 32'h0);
        d_req = 1'b0;
        rst = 1'b0;
        tick();
        check("rststore.no_ready2", 32'(d_ready), 32'h0);
        d_access("rststore.readback", 1'b0, 2'b10, 'h104, 32'h0, 1'b0);

        // Randomized mix of fetches, loads and stores over a scratch region.
        for (int i = 0; i < 150; i++) begin
            int a;
            a = 'h200 + int'($urandom_range(0, 511));
            if ($urandom_range(0, 4) == 0)
                fetch($sformatf("rnd%0d.f", i), a);
            else
                d_access($sformatf("rnd%0d.d", i), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)), a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
